// File: rtl/stream_buffer_writer_pkg.sv
// -----------------------------------------------------------------------------
// stream_buf_pkg
// Shared widths, types and the modulo-add helper used by the stream buffer
// writer and its ring pointer sub-module.
//   ADDR_W / DATA_W : buffer address and data widths (8 bits each)
//   addr_t / data_t : address and data byte types
//   addr_ext_t      : address type with one carry bit, used for wrap maths
//   mod_add()       : (a + b) mod depth, valid for a < depth and b <= depth
// -----------------------------------------------------------------------------
package stream_buf_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W:0]   addr_ext_t;

   // A single conditional subtract is enough because both operands are
   // bounded by depth, so the raw sum is always below 2*depth.
   function automatic addr_t mod_add(input addr_t a, input addr_t b, input addr_ext_t depth);
      addr_ext_t sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= depth) begin
         sum = sum - depth;
      end else begin
         sum = sum;
      end
      return sum[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/stream_buffer_writer_if.sv
// -----------------------------------------------------------------------------
// stream_buffer_writer_if
// Bundles the upstream sample handshake, the buffer write port, the window
// read addresses and the consumer/status signals of stream_buffer_writer.
//   slave  modport : used by the writer block
//   master modport : used by whatever drives samples and consumes windows
// Parameter N must match the N of the attached stream_buffer_writer.
// Optional macro STREAM_WRITER_FLUSH_EN adds the synchronous flush input.
// -----------------------------------------------------------------------------
interface stream_buffer_writer_if #(
   parameter int N = 8
) ();
   import stream_buf_pkg::*;

   logic  s_valid;
   data_t s_data;
   logic  s_ready;
   logic  wr_en;
   addr_t wr_addr;
   data_t wr_data;
   addr_t rd_addr [0:N-1];
   logic  win_valid;
   logic  win_advance;
   addr_t occupancy;
   logic  adv_err;
`ifdef STREAM_WRITER_FLUSH_EN
   logic  flush;

   modport slave (
      input  s_valid, s_data, win_advance, flush,
      output s_ready, wr_en, wr_addr, wr_data, rd_addr, win_valid, occupancy, adv_err
   );

   modport master (
      output s_valid, s_data, win_advance, flush,
      input  s_ready, wr_en, wr_addr, wr_data, rd_addr, win_valid, occupancy, adv_err
   );
`else
   modport slave (
      input  s_valid, s_data, win_advance,
      output s_ready, wr_en, wr_addr, wr_data, rd_addr, win_valid, occupancy, adv_err
   );

   modport master (
      output s_valid, s_data, win_advance,
      input  s_ready, wr_en, wr_addr, wr_data, rd_addr, win_valid, occupancy, adv_err
   );
`endif

endinterface

// File: rtl/stream_buffer_writer_ring_ptr.sv
// -----------------------------------------------------------------------------
// ring_ptr
// Pointer register into a ring of DEPTH entries; on adv it moves forward by
// INC entries, wrapping modulo DEPTH. clr returns it to entry 0 on the next
// edge and takes priority over adv.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (pointer -> 0)
//   clr  : synchronous clear
//   adv  : advance by INC
//   ptr  : current pointer value (registered)
// -----------------------------------------------------------------------------
module ring_ptr
   import stream_buf_pkg::*;
#(
   parameter int DEPTH = 24,
   parameter int INC   = 1
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  clr,
   input  logic  adv,
   output addr_t ptr
);

   localparam addr_ext_t DEPTH_X = addr_ext_t'(DEPTH);
   localparam addr_t     INC_A   = addr_t'(INC);

   addr_t ptr_q;
   addr_t ptr_d;

   // Next pointer: clear, modulo advance, or hold.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = 8'h00;
      end else if (adv) begin
         ptr_d = mod_add(ptr_q, INC_A, DEPTH_X);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= 8'h00;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/stream_buffer_writer.sv
// -----------------------------------------------------------------------------
// stream_buffer_writer
// Writes an upstream byte stream into an external ring buffer of Buffer_size
// bytes and exposes a sliding window of N read addresses over the oldest
// unconsumed samples. Each window advance frees STRIDE entries.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : stream_buffer_writer_if.slave
//          s_valid/s_data/s_ready       upstream handshake
//          wr_en/wr_addr/wr_data        buffer write port (same-edge commit)
//          rd_addr[0:N-1]               window read addresses
//          win_valid/win_advance        window handshake with the consumer
//          occupancy                    resident unconsumed sample count
//          adv_err                      sticky "advance without window" flag
// Optional macro STREAM_WRITER_FLUSH_EN adds bus.flush, a synchronous clear of
// both pointers and the count that blocks same-cycle accepts and advances.
// -----------------------------------------------------------------------------
module stream_buffer_writer
   import stream_buf_pkg::*;
#(
   parameter int Buffer_size = 24,
   parameter int N           = 8,
   parameter int STRIDE      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   stream_buffer_writer_if.slave  bus
);

   localparam addr_ext_t DEPTH_X  = addr_ext_t'(Buffer_size);
   localparam addr_ext_t N_X      = addr_ext_t'(N);
   localparam addr_t     STRIDE_A = addr_t'(STRIDE);

   addr_t count_q;
   addr_t count_d;
   logic  adv_err_q;
   logic  adv_err_d;

   addr_t wr_ptr_s;
   addr_t rd_ptr_s;
   logic  flush_s;
   logic  s_ready_s;
   logic  accept_s;
   logic  win_valid_s;
   logic  advance_s;
   logic  illegal_s;

`ifdef STREAM_WRITER_FLUSH_EN
   assign flush_s = bus.flush;
`else
   assign flush_s = 1'b0;
`endif

   // Readiness and window validity come only from the registered count, so
   // an advance in the same cycle cannot open room for a write when full.
   assign s_ready_s   = ({1'b0, count_q} < DEPTH_X) & ~flush_s;
   assign win_valid_s = ({1'b0, count_q} >= N_X);

   // rst gating keeps wr_en low while reset is held even though s_ready is 1.
   assign accept_s    = bus.s_valid & s_ready_s & rst;
   assign advance_s   = bus.win_advance & win_valid_s & ~flush_s;
   assign illegal_s   = bus.win_advance & ~win_valid_s & ~flush_s;

   // Next count and sticky error flag.
   always_comb begin
      count_d   = count_q;
      adv_err_d = adv_err_q | illegal_s;
      if (flush_s) begin
         count_d = 8'h00;
      end else begin
         // advance_s implies count >= N >= STRIDE, so this cannot underflow.
         count_d = count_q + (accept_s ? 8'h01 : 8'h00) - (advance_s ? STRIDE_A : 8'h00);
      end
   end

   // Count and error registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= 8'h00;
         adv_err_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         adv_err_q <= adv_err_d;
      end
   end

   ring_ptr #(
      .DEPTH (Buffer_size),
      .INC   (1)
   ) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_s),
      .adv   (accept_s),
      .ptr   (wr_ptr_s)
   );

   ring_ptr #(
      .DEPTH (Buffer_size),
      .INC   (STRIDE)
   ) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_s),
      .adv   (advance_s),
      .ptr   (rd_ptr_s)
   );

   for (genvar g = 0; g < N; g++) begin : g_rd_addr
      assign bus.rd_addr[g] = mod_add(rd_ptr_s, addr_t'(g), DEPTH_X);
   end

   assign bus.s_ready   = s_ready_s;
   assign bus.wr_en     = accept_s;
   assign bus.wr_addr   = wr_ptr_s;
   assign bus.wr_data   = bus.s_data;
   assign bus.win_valid = win_valid_s;
   assign bus.occupancy = count_q;
   assign bus.adv_err   = adv_err_q;

endmodule

// File: doc/stream_buffer_writer.md
STREAM_BUFFER_WRITER -- requirements
Module: stream_buffer_writer

Interface
REQ-001 SHALL have parameter Buffer_size, default 24, ring depth in bytes (2..255).
REQ-002 SHALL have parameter N, default 8, window taps (1..Buffer_size).
REQ-003 SHALL have parameter STRIDE, default 1, entries freed per window advance (1..N).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_valid  input  1  upstream sample valid.
REQ-007 SHALL have port s_data  input  8  upstream sample byte.
REQ-008 SHALL have port s_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port wr_en  output  1  buffer write enable.
REQ-010 SHALL have port wr_addr  output  8  buffer write address.
REQ-011 SHALL have port wr_data  output  8  buffer write byte.
REQ-012 SHALL have port rd_addr  output  8 x N (unpacked [0:N-1])  window read addresses.
REQ-013 SHALL have port win_valid  output  1  N unconsumed samples resident.
REQ-014 SHALL have port win_advance  input  1  consumer done with current window.
REQ-015 SHALL have port occupancy  output  8  resident unconsumed sample count.
REQ-016 SHALL have port adv_err  output  1  sticky illegal-advance flag.

Function
REQ-017 SHALL keep registers wr_ptr, rd_ptr (0..Buffer_size-1) and count (0..Buffer_size).
REQ-018 SHALL drive s_ready = (count < Buffer_size), from registered count only.
REQ-019 SHALL drive wr_en = s_valid & s_ready, wr_addr = wr_ptr, wr_data = s_data, combinationally (zero latency; buffer commits on same edge).
REQ-020 SHALL on accept advance wr_ptr by 1, wrapping Buffer_size-1 -> 0.
REQ-021 SHALL drive rd_addr[i] = (rd_ptr + i) mod Buffer_size for i = 0..N-1.
REQ-022 SHALL drive win_valid = (count >= N), registered-count based; first valid cycle is the cycle after the Nth accepted write.
REQ-023 SHALL on win_advance & win_valid add STRIDE to rd_ptr modulo Buffer_size and subtract STRIDE from count.
REQ-024 SHALL on accept and legal advance in the same cycle update count by +1-STRIDE.
REQ-025 SHALL not accept a write when full, even with a same-cycle advance; s_ready rises the next cycle.
REQ-026 SHALL on win_advance while !win_valid leave pointers/count unchanged and set adv_err until reset.
REQ-027 SHALL drive occupancy = count.

Reset
REQ-028 SHALL on rst low immediately clear wr_ptr, rd_ptr, count, adv_err; outputs then s_ready=1, wr_en=0 (regardless of s_valid), win_valid=0, occupancy=0, rd_addr[i]=i.
REQ-029 SHALL, reset asserted mid-stream, drop the in-flight sample; no write occurs during reset.

Configuration
REQ-030 SHALL, with STREAM_WRITER_FLUSH_EN defined, add input flush (1 bit): synchronous, clears wr_ptr, rd_ptr, count next edge, ignores same-cycle accept/advance, forces s_ready=0 and wr_en=0 in that cycle; adv_err untouched.
REQ-031 SHALL, without STREAM_WRITER_FLUSH_EN, have no flush port or logic.

Structure
REQ-032 SHALL place ADDR_W=8, DATA_W=8, typedefs addr_t and data_t in shared package stream_buf_pkg.
REQ-033 SHALL use one sub-module ring_ptr (pointer register with modulo add of parameterised increment), instantiated for wr_ptr and rd_ptr.

Verification (Buffer_size=24, N=8, STRIDE=1)
REQ-034 SHALL cover: 8 back-to-back writes 0x10..0x17 -> wr_addr 0..7, win_valid=1 next cycle, rd_addr 0..7, occupancy=8.
REQ-035 SHALL cover: 24 writes, no advance -> s_ready=0, occupancy=24; 25th s_valid holds, wr_en=0.
REQ-036 SHALL cover: full plus simultaneous s_valid and win_advance -> no write, occupancy=23, s_ready=1 next cycle.
REQ-037 SHALL cover: wrap, rd_ptr=20 -> rd_addr = 20,21,22,23,0,1,2,3; wr_ptr 23 -> 0 after accept.
REQ-038 SHALL cover: win_advance at occupancy=3 -> adv_err=1, rd_ptr/occupancy unchanged; rst low clears it.
REQ-039 SHALL cover: rst low mid-burst at occupancy=12 -> occupancy=0, win_valid=0, s_ready=1 during reset.
